ghost_mode_scheduler: RTL and testbench
=======================================

GHOST_MODE_SCHEDULER -- requirements
Module: ghost_mode_scheduler

Interface
REQ-001 Parameter SCATTER_FRAMES, default 420: length of each scatter phase, in frames.
REQ-002 Parameter CHASE_FRAMES, default 1200: length of each chase phase, in frames.
REQ-003 Parameter FRIGHT_FRAMES, default 360: length of frightened mode, in frames.
REQ-004 Parameter FLASH_FRAMES, default 120: number of final frightened frames during which flashing is asserted.
REQ-005 Parameter RELEASE_GAP, default 240: frames between successive ghost releases.
REQ-006 vga_pix_clk  in  1  single clock; all logic clocked on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 frame_stb  in  1  one-cycle pulse per frame; this is the only time base.
REQ-009 level_start  in  1  one-cycle pulse; starts a level.
REQ-010 power_pellet  in  1  one-cycle pulse; Pac-Man has eaten a power pellet.
REQ-011 pac_dead  in  1  one-cycle pulse; Pac-Man has died.
REQ-012 ghost_eaten  in  4  one-cycle pulses, one bit per ghost.
REQ-013 mode  out  2  current mode: 0 IDLE, 1 SCATTER, 2 CHASE, 3 FRIGHT.
REQ-014 reverse  out  1  one-cycle pulse commanding all ghosts to reverse direction.
REQ-015 flash  out  1  high during the last FLASH_FRAMES frames of FRIGHT.
REQ-016 released  out  4  per-ghost released-from-house flags.
REQ-017 eaten  out  4  per-ghost "eaten during current FRIGHT" flags.
REQ-018 eat_count  out  3  number of ghosts eaten in the current FRIGHT, range 0-4; this is the score-multiplier index.
REQ-019 phase  out  3  scatter/chase phase index, 0-7.

Function
REQ-020 FSM states are IDLE, SCATTER, CHASE and FRIGHT; mode is the registered encoding of the state.
REQ-021 IDLE -> SCATTER on level_start: phase_timer=0, phase=0, release_timer=0, released=4'b0001.
REQ-022 Phase and release timers advance only on cycles where frame_stb=1; they hold otherwise.
REQ-023 In SCATTER, when the timer reaches SCATTER_FRAMES-1 on a frame_stb: next state CHASE, timer cleared, phase incremented.
REQ-024 In CHASE, when the timer reaches CHASE_FRAMES-1 on a frame_stb and phase<7: next state SCATTER, timer cleared, phase incremented.
REQ-025 When phase=7 in CHASE, the state stays CHASE indefinitely and the timer saturates.
REQ-026 reverse pulses for exactly one cycle, in the cycle after any SCATTER<->CHASE transition and after entry to FRIGHT.
REQ-027 reverse does not pulse on the FRIGHT exit or on the IDLE->SCATTER transition.
REQ-028 power_pellet in SCATTER or CHASE: save the prior state, go to FRIGHT, set fright_timer=0, clear eaten and eat_count; the phase timer freezes.
REQ-029 power_pellet while already in FRIGHT restarts fright_timer at 0 and clears eaten and eat_count; reverse pulses again.
REQ-030 power_pellet in IDLE is ignored.
REQ-031 FRIGHT ends when fright_timer reaches FRIGHT_FRAMES-1 on a frame_stb; the state returns to the saved state, the phase timer resumes from its frozen value, and eaten and eat_count clear.
REQ-032 flash = (state==FRIGHT) && (fright_timer >= FRIGHT_FRAMES-FLASH_FRAMES); flash is registered.
REQ-033 ghost_eaten[i] in FRIGHT with released[i]=1 and eaten[i]=0 sets eaten[i] and increments eat_count.
REQ-034 Multiple ghost_eaten bits set in the same cycle each increment eat_count; the increment is the popcount of the qualifying bits.
REQ-035 ghost_eaten outside FRIGHT, or for a ghost already eaten or not released, is ignored.
REQ-036 Ghost releases: released[i] (i=1..3) sets when release_timer reaches i*RELEASE_GAP; release_timer counts in every non-IDLE state, including FRIGHT, and saturates at 3*RELEASE_GAP; released bits are sticky until IDLE.
REQ-037 pac_dead in any non-IDLE state goes to IDLE next cycle and clears all timers, released, eaten, eat_count, phase and flash.
REQ-038 Priority in the same cycle: level_start > pac_dead > power_pellet > timer expiry > ghost_eaten.
REQ-039 level_start in any state performs the REQ-021 restart, including in the middle of FRIGHT.
REQ-040 All outputs are registered; every response appears one cycle after the causing input.
REQ-041 Timers are wide enough for the largest parameter value; when a counter saturates it holds and never wraps.

Reset
REQ-042 While rst_n=0: state=IDLE, mode=0, reverse=0, flash=0, released=0, eaten=0, eat_count=0, phase=0, and all timers 0.
REQ-043 Reset assertion is asynchronous and reset release is synchronized to vga_pix_clk; reset mid-FRIGHT discards the saved state.

Verification
REQ-044 rst_n low, then level_start, then 420 frame_stb -> mode 1 then 2, one reverse pulse, phase=1, released=0001 until frame 240, then 0011.
REQ-045 power_pellet at scatter frame 100, then 360 frame_stb -> mode=3, reverse pulse, flash rises after 240 fright frames, return to mode 1 with the remaining 320 scatter frames intact.
REQ-046 In FRIGHT with all ghosts released, ghost_eaten=4'b0101, then 4'b0101 again, then 4'b1000 -> eat_count 2, 2, 3; eaten=1101.
REQ-047 Complete 7 phase transitions -> phase=7, mode=2 permanently, no further reverse pulses after 10000 more frames.
REQ-048 level_start and pac_dead in the same cycle during FRIGHT -> state SCATTER, phase=0, released=0001, eat_count=0.
REQ-049 power_pellet in IDLE -> no mode change and no reverse pulse; rst_n pulsed low mid-CHASE -> all outputs zero immediately.

Source files
------------

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: frame-timed scatter/chase/frightened ghost mode sequencer
// with staggered ghost release and per-fright eat tracking.
module ghost_mode_scheduler #(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int RELEASE_GAP    = 240
) (
  input  logic       vga_pix_clk,
  input  logic       rst_n,
  input  logic       frame_stb,
  input  logic       level_start,
  input  logic       power_pellet,
  input  logic       pac_dead,
  input  logic [3:0] ghost_eaten,
  output logic [1:0] mode,
  output logic       reverse,
  output logic       flash,
  output logic [3:0] released,
  output logic [3:0] eaten,
  output logic [2:0] eat_count,
  output logic [2:0] phase
);
  typedef enum logic [1:0] {IDLE, SCATTER, CHASE, FRIGHT} state_t;
  localparam int PT_MAX = SCATTER_FRAMES > CHASE_FRAMES ? SCATTER_FRAMES : CHASE_FRAMES;
  localparam int PTW = $clog2(PT_MAX + 1);
  localparam int FTW = $clog2(FRIGHT_FRAMES + 1);
  localparam int RTW = $clog2(3 * RELEASE_GAP + 1);
  localparam logic [PTW-1:0] S_END = PTW'(SCATTER_FRAMES - 1);
  localparam logic [PTW-1:0] C_END = PTW'(CHASE_FRAMES - 1);
  localparam logic [FTW-1:0] F_END = FTW'(FRIGHT_FRAMES - 1);
  localparam logic [FTW-1:0] FL_START = FTW'(FRIGHT_FRAMES - FLASH_FRAMES);
  localparam logic [RTW-1:0] G1 = RTW'(RELEASE_GAP);
  localparam logic [RTW-1:0] G2 = RTW'(2 * RELEASE_GAP);
  localparam logic [RTW-1:0] G3 = RTW'(3 * RELEASE_GAP);
  state_t state, state_n, saved, saved_n;
  logic [PTW-1:0] pt, pt_n;
  logic [FTW-1:0] ft, ft_n;
  logic [RTW-1:0] rt, rt_n;
  logic [3:0] eaten_n, released_n, q;
  logic [2:0] cnt_n, phase_n, q_cnt;
  logic rev_n, flash_n, rst_i;
  logic [1:0] rst_q;
  // Async assert, clock-synchronous release of the internal reset
  always_ff @(posedge vga_pix_clk or negedge rst_n)
    if (!rst_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_i = rst_q[1];
  assign mode = state;
  assign q = ghost_eaten & released & ~eaten;
  assign q_cnt = 3'(q[0]) + 3'(q[1]) + 3'(q[2]) + 3'(q[3]);
  always_comb begin
    state_n = state;
    saved_n = saved;
    pt_n = pt;
    ft_n = ft;
    rt_n = rt;
    eaten_n = eaten;
    cnt_n = eat_count;
    phase_n = phase;
    rev_n = 1'b0;
    if (level_start) begin
      state_n = SCATTER;
      saved_n = IDLE;
      pt_n = '0;
      ft_n = '0;
      rt_n = '0;
      eaten_n = '0;
      cnt_n = '0;
      phase_n = '0;
    end else if (pac_dead) begin
      state_n = IDLE;
      saved_n = IDLE;
      pt_n = '0;
      ft_n = '0;
      rt_n = '0;
      eaten_n = '0;
      cnt_n = '0;
      phase_n = '0;
    end else if (state != IDLE) begin
      rt_n = (frame_stb && rt != G3) ? rt + 1'b1 : rt;
      if (power_pellet) begin
        saved_n = (state == FRIGHT) ? saved : state;
        state_n = FRIGHT;
        ft_n = '0;
        eaten_n = '0;
        cnt_n = '0;
        rev_n = 1'b1;
      end else if (state == FRIGHT) begin
        if (frame_stb && ft == F_END) begin
          state_n = saved;
          ft_n = '0;
          eaten_n = '0;
          cnt_n = '0;
        end else begin
          ft_n = frame_stb ? ft + 1'b1 : ft;
          eaten_n = eaten | q;
          cnt_n = eat_count + q_cnt;
        end
      end else if (frame_stb) begin
        if ((state == SCATTER && pt == S_END) || (state == CHASE && pt == C_END && phase != 3'd7)) begin
          state_n = (state == SCATTER) ? CHASE : SCATTER;
          pt_n = '0;
          phase_n = phase + 3'd1;
          rev_n = 1'b1;
        end else if (!(state == CHASE && pt == C_END)) begin
          pt_n = pt + 1'b1;
        end
      end
    end
    released_n = {rt_n >= G3, rt_n >= G2, rt_n >= G1, state_n != IDLE};
    flash_n = (state_n == FRIGHT) && (ft_n >= FL_START);
  end
  always_ff @(posedge vga_pix_clk or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      saved <= IDLE;
      pt <= '0;
      ft <= '0;
      rt <= '0;
      eaten <= '0;
      eat_count <= '0;
      phase <= '0;
      released <= '0;
      reverse <= 1'b0;
      flash <= 1'b0;
    end else begin
      state <= state_n;
      saved <= saved_n;
      pt <= pt_n;
      ft <= ft_n;
      rt <= rt_n;
      eaten <= eaten_n;
      eat_count <= cnt_n;
      phase <= phase_n;
      released <= released_n;
      reverse <= rev_n;
      flash <= flash_n;
    end
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler: table vectors, directed scenarios and random stimulus
// checked against a frame-counting reference model of the ghost scheduler.
module tb_ghost_mode_scheduler;
  localparam int S = 420, C = 1200, F = 360, FL = 120, G = 240;
  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_stb = 0, level_start = 0, power_pellet = 0, pac_dead = 0;
  logic [3:0] ghost_eaten = '0;
  logic [1:0] mode;
  logic reverse, flash;
  logic [3:0] released, eaten;
  logic [2:0] eat_count, phase;
  int n_chk = 0, n_fail = 0, rev_seen = 0;
  int m_state, m_saved, m_pt, m_ft, m_rt, m_phase;
  logic [3:0] m_eaten;

  ghost_mode_scheduler #(.SCATTER_FRAMES(S), .CHASE_FRAMES(C), .FRIGHT_FRAMES(F),
    .FLASH_FRAMES(FL), .RELEASE_GAP(G)) dut (
    .vga_pix_clk(clk), .rst_n(rst_n), .frame_stb(frame_stb), .level_start(level_start),
    .power_pellet(power_pellet), .pac_dead(pac_dead), .ghost_eaten(ghost_eaten),
    .mode(mode), .reverse(reverse), .flash(flash), .released(released), .eaten(eaten),
    .eat_count(eat_count), .phase(phase));

  always #5 clk = ~clk;

  typedef struct {
    logic ls, pd, pp, fs;
    logic [3:0] ge;
    logic [1:0] mode;
    logic rev;
    logic [3:0] rel;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_released();
    if (m_state == 0) return 4'b0000;
    return {m_rt >= 3 * G, m_rt >= 2 * G, m_rt >= G, 1'b1};
  endfunction

  function automatic int m_bundle(input logic rev);
    logic fl;
    fl = (m_state == 3) && (m_ft >= F - FL);
    return int'({m_state[1:0], rev, fl, m_released(), m_eaten, 3'($countones(m_eaten)), m_phase[2:0]});
  endfunction

  task automatic m_clear();
    m_state = 0; m_saved = 0; m_pt = 0; m_ft = 0; m_rt = 0; m_phase = 0; m_eaten = '0;
  endtask

  task automatic step(input logic ls, pd, pp, fs, input logic [3:0] ge);
    logic rev;
    logic [3:0] rel;
    int len;
    level_start = ls; pac_dead = pd; power_pellet = pp; frame_stb = fs; ghost_eaten = ge;
    @(posedge clk);
    rev = 1'b0;
    rel = m_released();
    if (ls) begin
      m_clear();
      m_state = 1;
    end else if (pd) begin
      m_clear();
    end else if (m_state != 0) begin
      if (fs && m_rt < 3 * G) m_rt++;
      if (pp) begin
        if (m_state != 3) m_saved = m_state;
        m_state = 3; m_ft = 0; m_eaten = '0; rev = 1'b1;
      end else if (m_state == 3) begin
        if (fs && m_ft + 1 == F) begin
          m_state = m_saved; m_ft = 0; m_eaten = '0;
        end else begin
          if (fs) m_ft++;
          m_eaten = m_eaten | (ge & rel);
        end
      end else if (fs) begin
        len = (m_state == 1) ? S : C;
        if (m_pt + 1 < len) m_pt++;
        else if (m_state == 1 || m_phase < 7) begin
          m_state = 3 - m_state; m_pt = 0; m_phase++; rev = 1'b1;
        end
      end
    end
    #1;
    chk("model", int'({mode, reverse, flash, released, eaten, eat_count, phase}), m_bundle(rev));
    if (reverse) rev_seen++;
    level_start = 0; pac_dead = 0; power_pellet = 0; frame_stb = 0; ghost_eaten = '0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 4'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", int'({mode, reverse, flash, released, eaten, eat_count, phase}), 0);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'b0);
  endtask

  initial begin
    tbl = '{
      '{0,0,1,0,4'b0000, 2'd0,0,4'b0000,3'd0},
      '{1,0,0,0,4'b0000, 2'd1,0,4'b0001,3'd0},
      '{0,0,1,0,4'b0000, 2'd3,1,4'b0001,3'd0},
      '{0,0,0,1,4'b0000, 2'd3,0,4'b0001,3'd0},
      '{0,0,0,0,4'b0101, 2'd3,0,4'b0001,3'd1},
      '{0,0,0,0,4'b0001, 2'd3,0,4'b0001,3'd1},
      '{0,0,1,0,4'b0000, 2'd3,1,4'b0001,3'd0},
      '{0,1,0,0,4'b0000, 2'd0,0,4'b0000,3'd0},
      '{0,0,0,0,4'b1111, 2'd0,0,4'b0000,3'd0},
      '{1,0,0,0,4'b0000, 2'd1,0,4'b0001,3'd0},
      '{1,1,0,1,4'b0000, 2'd1,0,4'b0001,3'd0},
      '{0,1,0,0,4'b0000, 2'd0,0,4'b0000,3'd0}};
    #2;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ls, tbl[i].pd, tbl[i].pp, tbl[i].fs, tbl[i].ge);
      chk($sformatf("tbl%0d", i), int'({mode, reverse, released, eat_count}),
          int'({tbl[i].mode, tbl[i].rev, tbl[i].rel, tbl[i].cnt}));
    end
    // first scatter phase and first release
    step(1, 0, 0, 0, 4'b0);
    rev_seen = 0;
    frames(239);
    chk("rel_before_gap", released, 4'b0001);
    frames(1);
    chk("rel_at_gap", released, 4'b0011);
    chk("mode_scatter", mode, 1);
    frames(180);
    chk("mode_chase", mode, 2);
    chk("phase_one", phase, 1);
    chk("one_reverse", rev_seen, 1);
    // fright mid-scatter with phase timer frozen
    step(1, 0, 0, 0, 4'b0);
    frames(100);
    step(0, 0, 1, 0, 4'b0);
    chk("fright_mode", mode, 3);
    chk("fright_rev", reverse, 1);
    frames(239);
    chk("flash_low", flash, 0);
    frames(1);
    chk("flash_high", flash, 1);
    rev_seen = 0;
    frames(120);
    chk("back_scatter", mode, 1);
    chk("no_exit_rev", rev_seen, 0);
    frames(319);
    chk("scatter_left", mode, 1);
    frames(1);
    chk("scatter_done", mode, 2);
    // eat counting with all ghosts released
    step(1, 0, 0, 0, 4'b0);
    frames(720);
    step(0, 0, 1, 0, 4'b0);
    step(0, 0, 0, 0, 4'b0101);
    chk("eat_a", eat_count, 2);
    step(0, 0, 0, 0, 4'b0101);
    chk("eat_b", eat_count, 2);
    step(0, 0, 0, 0, 4'b1000);
    chk("eat_c", eat_count, 3);
    chk("eaten_mask", eaten, 4'b1101);
    step(1, 1, 0, 0, 4'b0);
    chk("restart_bundle", int'({mode, phase, released, eat_count}), int'({2'd1, 3'd0, 4'b0001, 3'd0}));
    // run to final chase and stay there
    frames(4 * S + 3 * C);
    chk("final_phase", phase, 7);
    rev_seen = 0;
    frames(10000);
    chk("final_mode", mode, 2);
    chk("final_no_rev", rev_seen, 0);
    @(negedge clk);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 20000; i++)
      step(($urandom_range(0, 3999) == 0) || (m_state == 0 && $urandom_range(0, 49) == 0),
           $urandom_range(0, 5999) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
